uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter RSP_TIMEOUT, default 255: max cycles waited for RF_RdData_Valid or ALU_OUT_VLD.
REQ-002 CLK  input  1  clock, all logic rising-edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 RX_P_DATA  input  8  received byte from UART RX.
REQ-005 RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid.
REQ-006 RF_WrEn / RF_RdEn  output  1 each  register-file write / read strobe.
REQ-007 RF_Address  output  4  register-file address.
REQ-008 RF_WrData  output  8  register-file write data.
REQ-009 RF_RdData  input  8;  RF_RdData_Valid  input  1  read return.
REQ-010 ALU_EN  output  1;  ALU_FUN  output  4  ALU start strobe and function.
REQ-011 ALU_OUT  input  16;  ALU_OUT_VLD  input  1  ALU result.
REQ-012 CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-013 TX_P_DATA  output  8;  TX_D_VLD  output  1  byte to UART TX.
REQ-014 TX_BUSY  input  1  UART TX frame in progress.
REQ-015 CMD_ERR  output  1  one-cycle pulse on timeout or dropped byte.

Function
REQ-016 All outputs registered; command frames: 0xAA addr data (write), 0xBB addr (read), 0xCC A B fun (ALU with operands), 0xDD fun (ALU, no operands); addr/fun use byte bits [3:0].
REQ-017 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_WAIT_LO, TX_HI, TX_WAIT_HI.
REQ-018 IDLE: RX_D_VLD with 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUN; any other byte ignored, no CMD_ERR.
REQ-019 WR_ADDR: on RX_D_VLD latch address ->WR_DATA; WR_DATA: on RX_D_VLD, RF_WrEn=1 for exactly one cycle (cycle after strobe) with latched address and byte ->IDLE.
REQ-020 RD_ADDR: on RX_D_VLD, RF_RdEn=1 one cycle next cycle with address ->RD_WAIT; RD_WAIT: on RF_RdData_Valid capture RF_RdData into low response byte, 1-byte response ->TX_LO.
REQ-021 ALU_A / ALU_B: on RX_D_VLD one-cycle RF_WrEn to address 0 / 1 with the byte, ->ALU_B / ALU_FUN.
REQ-022 ALU_FUN: on RX_D_VLD, ALU_EN=1 one cycle next cycle, ALU_FUN held at latched value until IDLE ->ALU_WAIT; ALU_WAIT: on ALU_OUT_VLD capture ALU_OUT, 2-byte response ->TX_LO.
REQ-023 CLK_GATE_EN=1 from ALU_FUN entry until ALU_WAIT exit; 0 otherwise.
REQ-024 TX_LO: when TX_BUSY=0, TX_P_DATA=low byte, TX_D_VLD=1 one cycle ->TX_WAIT_LO; TX_WAIT_LO: wait TX_BUSY high then low ->TX_HI (2-byte) or IDLE (1-byte); TX_HI/TX_WAIT_HI same for ALU_OUT[15:8], ->IDLE.
REQ-025 TX_P_DATA holds last value when TX_D_VLD=0.
REQ-026 Timeout counter cleared on RD_WAIT/ALU_WAIT entry; if RSP_TIMEOUT cycles elapse without valid: CMD_ERR pulse, no response, ->IDLE.
REQ-027 RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: byte dropped, CMD_ERR pulse, state unchanged.
REQ-028 Valid return and timeout expiry in same cycle: valid wins, no CMD_ERR.
REQ-029 Next command accepted in IDLE the cycle after return from TX_WAIT_*.

Reset
REQ-030 RST low: state IDLE, all strobes and CLK_GATE_EN 0, RF_Address/RF_WrData/ALU_FUN/TX_P_DATA 0, timeout counter 0, immediately and asynchronously.
REQ-031 RST mid-command or mid-response: frame abandoned, no strobe after release; first byte after release decoded as command.

Verification
REQ-032 RX 0xAA,0x05,0x3C -> single RF_WrEn, RF_Address=5, RF_WrData=0x3C; no TX.
REQ-033 RX 0xBB,0x05, RF returns 0x3C after 3 cycles -> one RF_RdEn, one TX_D_VLD with 0x3C.
REQ-034 RX 0xCC,0x12,0x34,0x01, ALU_OUT=0x0046 -> RF writes addr0=0x12, addr1=0x34, ALU_EN with ALU_FUN=1, TX bytes 0x46 then 0x00, second only after TX_BUSY high-then-low.
REQ-035 RX 0xBB,0x02, no RF_RdData_Valid -> CMD_ERR after 255 cycles, no TX, next 0xAA frame works.
REQ-036 RX byte during ALU_WAIT -> CMD_ERR pulse, response still correct; RST asserted in TX_WAIT_LO -> no TX_HI byte.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command controller and its UART RX/TX, register file and ALU.
interface uart_cmd_ctrl_if;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic        RF_WrEn;
   logic        RF_RdEn;
   logic [3:0]  RF_Address;
   logic [7:0]  RF_WrData;
   logic [7:0]  RF_RdData;
   logic        RF_RdData_Valid;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_BUSY;
   logic        CMD_ERR;

   // Controller side
   modport master (
      input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR
   );

   // Peripheral / environment side
   modport slave (
      output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: turns RX byte frames into register-file / ALU operations and
// streams read or ALU results back through the UART TX.
module uart_cmd_ctrl #(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic            CLK,
   input  logic            RST,
   uart_cmd_ctrl_if.master bus_io
);
   localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);
   localparam logic [7:0] CMD_WR  = 8'hAA;
   localparam logic [7:0] CMD_RD  = 8'hBB;
   localparam logic [7:0] CMD_ALU = 8'hCC;
   localparam logic [7:0] CMD_FUN = 8'hDD;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN,
      ALU_WAIT, TX_LO, TX_WAIT_LO, TX_HI, TX_WAIT_HI
   } state_e;

   state_e            state_q, state_d;
   logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
   logic              tx_vld_q, tx_vld_d, err_q, err_d, cg_q, cg_d;
   logic [3:0]        addr_q, addr_d, fun_q, fun_d;
   logic [7:0]        wr_data_q, wr_data_d, tx_data_q, tx_data_d;
   logic [15:0]       rsp_q, rsp_d;
   logic              two_byte_q, two_byte_d, seen_q, seen_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic       rx_vld, busy, in_wait, rsp_vld, timeout, dropped;
   logic [7:0] rx_byte;

   assign rx_vld  = bus_io.RX_D_VLD;
   assign rx_byte = bus_io.RX_P_DATA;
   assign busy    = bus_io.TX_BUSY;
   assign in_wait = (state_q == RD_WAIT) || (state_q == ALU_WAIT);
   assign rsp_vld = ((state_q == RD_WAIT) && bus_io.RF_RdData_Valid) ||
                    ((state_q == ALU_WAIT) && bus_io.ALU_OUT_VLD);
   assign timeout = in_wait && (cnt_q == CNT_W'(RSP_TIMEOUT - 1));
   // Bytes arriving while a response is pending or being sent are discarded
   assign dropped = rx_vld && (in_wait || (state_q == TX_LO) || (state_q == TX_WAIT_LO) ||
                               (state_q == TX_HI) || (state_q == TX_WAIT_HI));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (rx_vld) begin
               case (rx_byte)
                  CMD_WR:  state_d = WR_ADDR;
                  CMD_RD:  state_d = RD_ADDR;
                  CMD_ALU: state_d = ALU_A;
                  CMD_FUN: state_d = ALU_FUN;
                  default: state_d = IDLE;
               endcase
            end
         end
         WR_ADDR:    if (rx_vld) state_d = WR_DATA;
         WR_DATA:    if (rx_vld) state_d = IDLE;
         RD_ADDR:    if (rx_vld) state_d = RD_WAIT;
         ALU_A:      if (rx_vld) state_d = ALU_B;
         ALU_B:      if (rx_vld) state_d = ALU_FUN;
         ALU_FUN:    if (rx_vld) state_d = ALU_WAIT;
         RD_WAIT, ALU_WAIT: begin
            if (rsp_vld)      state_d = TX_LO;
            else if (timeout) state_d = IDLE;
         end
         TX_LO:      if (!busy) state_d = TX_WAIT_LO;
         TX_WAIT_LO: if (seen_q && !busy) state_d = two_byte_q ? TX_HI : IDLE;
         TX_HI:      if (!busy) state_d = TX_WAIT_HI;
         TX_WAIT_HI: if (seen_q && !busy) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      alu_en_d   = 1'b0;
      tx_vld_d   = 1'b0;
      err_d      = dropped || (timeout && !rsp_vld);
      cg_d       = (state_d == ALU_FUN) || (state_d == ALU_WAIT);
      addr_d     = addr_q;
      wr_data_d  = wr_data_q;
      fun_d      = fun_q;
      tx_data_d  = tx_data_q;
      rsp_d      = rsp_q;
      two_byte_d = two_byte_q;
      seen_d     = seen_q;
      cnt_d      = cnt_q;
      if ((state_d != state_q) && ((state_d == RD_WAIT) || (state_d == ALU_WAIT)))
         cnt_d = '0;
      else if (in_wait)
         cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
         WR_ADDR: if (rx_vld) addr_d = rx_byte[3:0];
         WR_DATA: if (rx_vld) begin wr_en_d = 1'b1; wr_data_d = rx_byte; end
         RD_ADDR: if (rx_vld) begin rd_en_d = 1'b1; addr_d = rx_byte[3:0]; end
         ALU_A:   if (rx_vld) begin wr_en_d = 1'b1; addr_d = 4'd0; wr_data_d = rx_byte; end
         ALU_B:   if (rx_vld) begin wr_en_d = 1'b1; addr_d = 4'd1; wr_data_d = rx_byte; end
         ALU_FUN: if (rx_vld) begin alu_en_d = 1'b1; fun_d = rx_byte[3:0]; end
         RD_WAIT: begin
            if (bus_io.RF_RdData_Valid) begin
               rsp_d      = {8'h00, bus_io.RF_RdData};
               two_byte_d = 1'b0;
            end
         end
         ALU_WAIT: begin
            if (bus_io.ALU_OUT_VLD) begin
               rsp_d      = bus_io.ALU_OUT;
               two_byte_d = 1'b1;
            end
         end
         TX_LO: if (!busy) begin tx_vld_d = 1'b1; tx_data_d = rsp_q[7:0]; seen_d = 1'b0; end
         TX_HI: if (!busy) begin tx_vld_d = 1'b1; tx_data_d = rsp_q[15:8]; seen_d = 1'b0; end
         TX_WAIT_LO, TX_WAIT_HI: if (busy) seen_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         alu_en_q   <= 1'b0;
         tx_vld_q   <= 1'b0;
         err_q      <= 1'b0;
         cg_q       <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         fun_q      <= '0;
         tx_data_q  <= '0;
         rsp_q      <= '0;
         two_byte_q <= 1'b0;
         seen_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         alu_en_q   <= alu_en_d;
         tx_vld_q   <= tx_vld_d;
         err_q      <= err_d;
         cg_q       <= cg_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         fun_q      <= fun_d;
         tx_data_q  <= tx_data_d;
         rsp_q      <= rsp_d;
         two_byte_q <= two_byte_d;
         seen_q     <= seen_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus_io.RF_WrEn     = wr_en_q;
   assign bus_io.RF_RdEn     = rd_en_q;
   assign bus_io.RF_Address  = addr_q;
   assign bus_io.RF_WrData   = wr_data_q;
   assign bus_io.ALU_EN      = alu_en_q;
   assign bus_io.ALU_FUN     = fun_q;
   assign bus_io.CLK_GATE_EN = cg_q;
   assign bus_io.TX_P_DATA   = tx_data_q;
   assign bus_io.TX_D_VLD    = tx_vld_q;
   assign bus_io.CMD_ERR     = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: drives command frames, plays the RF / ALU / UART TX peers and
// compares every strobe and response byte with a frame-level expectation model.
module tb_uart_cmd_ctrl;
   logic CLK = 1'b0;
   logic RST;
   int   n_cmp = 0;
   int   n_err = 0;

   uart_cmd_ctrl_if bus ();
   uart_cmd_ctrl #(.RSP_TIMEOUT(255)) dut (.CLK(CLK), .RST(RST), .bus_io(bus));

   always #5 CLK = ~CLK;

   typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
   wr_t        wr_q[$], exp_wr[$];
   logic [3:0] rd_q[$], exp_rd[$], alu_q[$], exp_alu[$];
   logic [7:0] tx_q[$], exp_tx[$];
   int         err_seen = 0;
   int         exp_err  = 0;

   // Observed strobes, recorded once per cycle
   always @(negedge CLK) begin
      if (bus.RF_WrEn)  wr_q.push_back({bus.RF_Address, bus.RF_WrData});
      if (bus.RF_RdEn)  rd_q.push_back(bus.RF_Address);
      if (bus.ALU_EN)   alu_q.push_back(bus.ALU_FUN);
      if (bus.TX_D_VLD) tx_q.push_back(bus.TX_P_DATA);
      if (bus.CMD_ERR)  err_seen++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({bus.RF_WrEn, bus.RF_RdEn, bus.ALU_EN, bus.TX_D_VLD, bus.CMD_ERR,
                  bus.CLK_GATE_EN, bus.RF_Address, bus.RF_WrData, bus.ALU_FUN, bus.TX_P_DATA});
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
   endtask

   // sel: 0 = RF_RdEn, 1 = ALU_EN, 2 = TX_D_VLD
   task automatic wait_sig(input int sel, input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((sel == 0 && bus.RF_RdEn) || (sel == 1 && bus.ALU_EN) ||
             (sel == 2 && bus.TX_D_VLD)) begin
            hit = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   // UART TX peer: after each byte, optionally idle, then busy for a while, then release
   task automatic tx_respond(input int n);
      int early;
      for (int i = 0; i < n; i++) begin
         early = 0;
         wait_sig(2, 40, "tx_byte_seen");
         repeat ($urandom_range(3, 0)) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) early++;
         end
         bus.TX_BUSY = 1'b1;
         repeat ($urandom_range(5, 1)) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) early++;
         end
         bus.TX_BUSY = 1'b0;
         chk("tx_no_byte_before_busy_cycle", 32'(early), 32'd0);
      end
   endtask

   task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
      exp_wr.push_back({a[3:0], d});
      send_byte(8'hAA);
      send_byte(a);
      send_byte(d);
   endtask

   task automatic frame_rd(input logic [7:0] a, input logic [7:0] d, input int dly);
      exp_rd.push_back(a[3:0]);
      exp_tx.push_back(d);
      send_byte(8'hBB);
      send_byte(a);
      wait_sig(0, 4, "rd_strobe_seen");
      chk("cg_off_in_read", 32'(bus.CLK_GATE_EN), 32'd0);
      repeat (dly) @(negedge CLK);
      bus.RF_RdData       = d;
      bus.RF_RdData_Valid = 1'b1;
      @(negedge CLK);
      bus.RF_RdData_Valid = 1'b0;
      tx_respond(1);
   endtask

   task automatic frame_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] f, input logic [15:0] res, input int dly,
                            input bit poke);
      if (ops) begin
         exp_wr.push_back({4'd0, a});
         exp_wr.push_back({4'd1, b});
      end
      exp_alu.push_back(f[3:0]);
      exp_tx.push_back(res[7:0]);
      exp_tx.push_back(res[15:8]);
      send_byte(ops ? 8'hCC : 8'hDD);
      if (ops) begin
         send_byte(a);
         send_byte(b);
      end
      chk("cg_on_awaiting_fun", 32'(bus.CLK_GATE_EN), 32'd1);
      send_byte(f);
      wait_sig(1, 4, "alu_strobe_seen");
      chk("cg_on_in_alu_wait", 32'(bus.CLK_GATE_EN), 32'd1);
      if (poke) begin
         send_byte(8'hAA);
         exp_err++;
      end
      repeat (dly) @(negedge CLK);
      bus.ALU_OUT     = res;
      bus.ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      bus.ALU_OUT_VLD = 1'b0;
      tx_respond(2);
   endtask

   // Compare everything the DUT emitted since the last frame with the model
   task automatic end_frame(input string tag);
      wr_t        ow, ew;
      logic [7:0] ob, eb;
      repeat (4) @(negedge CLK);
      chk({tag, "_wr_count"},  32'(wr_q.size()),  32'(exp_wr.size()));
      chk({tag, "_rd_count"},  32'(rd_q.size()),  32'(exp_rd.size()));
      chk({tag, "_alu_count"}, 32'(alu_q.size()), 32'(exp_alu.size()));
      chk({tag, "_tx_count"},  32'(tx_q.size()),  32'(exp_tx.size()));
      chk({tag, "_err_count"}, 32'(err_seen),     32'(exp_err));
      chk({tag, "_cg_idle"},   32'(bus.CLK_GATE_EN), 32'd0);
      while (wr_q.size() > 0 && exp_wr.size() > 0) begin
         ow = wr_q.pop_front();
         ew = exp_wr.pop_front();
         chk({tag, "_wr"}, 32'(ow), 32'(ew));
      end
      while (rd_q.size() > 0 && exp_rd.size() > 0)
         chk({tag, "_rd_addr"}, 32'(rd_q.pop_front()), 32'(exp_rd.pop_front()));
      while (alu_q.size() > 0 && exp_alu.size() > 0)
         chk({tag, "_alu_fun"}, 32'(alu_q.pop_front()), 32'(exp_alu.pop_front()));
      while (tx_q.size() > 0 && exp_tx.size() > 0) begin
         ob = tx_q.pop_front();
         eb = exp_tx.pop_front();
         chk({tag, "_tx_byte"}, 32'(ob), 32'(eb));
      end
      wr_q.delete(); exp_wr.delete(); rd_q.delete(); exp_rd.delete();
      alu_q.delete(); exp_alu.delete(); tx_q.delete(); exp_tx.delete();
   endtask

   initial begin
      int         n, kind;
      logic [7:0] j;

      RST = 1'b0;
      bus.RX_P_DATA = '0;  bus.RX_D_VLD = 1'b0;
      bus.RF_RdData = '0;  bus.RF_RdData_Valid = 1'b0;
      bus.ALU_OUT   = '0;  bus.ALU_OUT_VLD = 1'b0;
      bus.TX_BUSY   = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", out_vec(), 32'd0);
      RST = 1'b1;

      // Directed frames with fixed values
      frame_wr(8'h05, 8'h3C);
      end_frame("wr_basic");
      frame_rd(8'h05, 8'h3C, 3);
      end_frame("rd_basic");
      frame_alu(1'b1, 8'h12, 8'h34, 8'h01, 16'h0046, 2, 1'b0);
      end_frame("alu_basic");

      // Timeout: no read return at all
      exp_rd.push_back(4'd2);
      send_byte(8'hBB);
      send_byte(8'h02);
      n = 0;
      while (n < 400) begin
         @(negedge CLK);
         n++;
         if (bus.CMD_ERR) break;
      end
      chk("timeout_cycles", 32'(n), 32'd255);
      exp_err++;
      end_frame("timeout");
      frame_wr(8'h0A, 8'h77);
      end_frame("wr_after_timeout");

      // Return arriving on the very last cycle before expiry must win
      exp_rd.push_back(4'd9);
      exp_tx.push_back(8'hE1);
      send_byte(8'hBB);
      send_byte(8'h39);
      repeat (254) @(negedge CLK);
      bus.RF_RdData       = 8'hE1;
      bus.RF_RdData_Valid = 1'b1;
      @(negedge CLK);
      bus.RF_RdData_Valid = 1'b0;
      tx_respond(1);
      end_frame("valid_at_expiry");

      // Byte received during ALU wait is dropped with an error pulse
      frame_alu(1'b0, 8'h00, 8'h00, 8'h0B, 16'h9D24, 5, 1'b1);
      end_frame("drop_in_alu_wait");

      // Randomized frames, with stray non-command bytes between them
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(2, 0) == 0) begin
            do j = 8'($urandom);
            while (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD);
            send_byte(j);
         end
         kind = $urandom_range(3, 0);
         case (kind)
            0: frame_wr(8'($urandom), 8'($urandom));
            1: frame_rd(8'($urandom), 8'($urandom), $urandom_range(8, 0));
            2: frame_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                         $urandom_range(8, 0), 1'b0);
            default: frame_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                               $urandom_range(8, 0), 1'b0);
         endcase
         end_frame("rnd");
      end

      // Reset while waiting for the first TX byte to finish: high byte never sent
      exp_alu.push_back(4'h7);
      exp_tx.push_back(8'hA5);
      send_byte(8'hDD);
      send_byte(8'h07);
      wait_sig(1, 4, "rst_alu_strobe_seen");
      bus.ALU_OUT     = 16'hC3A5;
      bus.ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      bus.ALU_OUT_VLD = 1'b0;
      wait_sig(2, 40, "rst_tx_lo_seen");
      bus.TX_BUSY = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("async_reset_outputs", out_vec(), 32'd0);
      @(negedge CLK);
      bus.TX_BUSY = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      frame_wr(8'h0C, 8'h5E);
      end_frame("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
